// File: rtl/pong_pkg.sv
// Shared Pong types: the tick scheduler's states, the fixed game-logic phase order
// and the helper that steps from one phase to the next.
package pong_pkg;

  localparam int NPHASE = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    PH_PADDLE  = 2'd0,
    PH_BALL    = 2'd1,
    PH_COLLIDE = 2'd2,
    PH_SCORE   = 2'd3
  } phase_t;

  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase stall watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT-th one combinationally; holds its count once expired, with no backpressure.
module phase_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic fastclk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  // Count holds the number of WAIT cycles already spent, so this is the last allowed one.
  assign expired = (count == LAST);

endmodule

// File: rtl/game_tick_scheduler.sv
// Runs one Pong frame per accepted tick: paddle, ball, collide, score, each as ISSUE then WAIT;
// 1-cycle start-to-strobe latency; ticks arriving while busy are dropped and counted.
module game_tick_scheduler
  import pong_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic              fastclk,
  input  logic              reset,
  input  logic              tick,
  input  logic              pause,
  input  logic [NPHASE-1:0] done,
  output logic [NPHASE-1:0] start,
  output logic [1:0]        phase,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err,
  output logic [7:0]        overrun_cnt
);

  sched_state_t state, state_nxt;
  phase_t       phase_q, phase_nxt;
  logic         wd_clear, wd_enable, wd_expired;
  logic         unit_done;
  logic         timeout_nxt;

  assign unit_done = done[phase_q];
  assign phase     = phase_q;

  phase_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .fastclk (fastclk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase_q <= PH_PADDLE;
    end else begin
      state   <= state_nxt;
      phase_q <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase_q;
    timeout_nxt = 1'b0;
    start       = '0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (tick && !pause) begin
          state_nxt = ISSUE;
          phase_nxt = PH_PADDLE;
        end
      end
      ISSUE: begin
        start[phase_q] = 1'b1;
        wd_clear       = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        wd_enable = 1'b1;
        // A unit finishing on the watchdog's last cycle still counts as a clean finish.
        if (unit_done || wd_expired) begin
          timeout_nxt = !unit_done;
          if (phase_q == PH_SCORE) begin
            state_nxt = FINISH;
          end else begin
            state_nxt = ISSUE;
            phase_nxt = next_phase(phase_q);
          end
        end
      end
      FINISH: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
        phase_nxt  = PH_PADDLE;
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = PH_PADDLE;
      end
    endcase
  end

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      timeout_err <= timeout_nxt;
      if (tick && (state != IDLE) && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: directed frames checked against a frame-level model every cycle,
// plus hand-computed cycle expectations for strobes, timeouts, overruns, pause and reset.
module tb_game_tick_scheduler;

  localparam int TIMEOUT = 8;

  logic       fastclk = 1'b0;
  logic       reset   = 1'b1;
  logic       tick    = 1'b0;
  logic       pause   = 1'b0;
  logic [3:0] done    = 4'h0;
  logic [3:0] start;
  logic [1:0] phase;
  logic       busy, frame_done, timeout_err;
  logic [7:0] overrun_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  game_tick_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .fastclk     (fastclk),
    .reset       (reset),
    .tick        (tick),
    .pause       (pause),
    .done        (done),
    .start       (start),
    .phase       (phase),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .overrun_cnt (overrun_cnt)
  );

  always #5 fastclk = ~fastclk;

  // Frame model: step 0 = strobe cycle, 1 = waiting on the unit, 2 = wrap-up cycle.
  typedef struct {
    bit busy;
    int ph;
    int step;
    int waited;
    bit err;
    int ovr;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t model_reset();
    mdl_t z;
    z.busy = 0; z.ph = 0; z.step = 0; z.waited = 0; z.err = 0; z.ovr = 0;
    return z;
  endfunction

  function automatic mdl_t model_step(mdl_t s, logic t, logic p, logic [3:0] d);
    mdl_t n = s;
    n.err = 0;
    if (!s.busy) begin
      if (t && !p) begin
        n.busy = 1; n.ph = 0; n.step = 0;
      end
    end else begin
      if (t && s.ovr < 255) n.ovr = s.ovr + 1;
      case (s.step)
        0: begin
          n.step = 1; n.waited = 0;
        end
        1: begin
          n.waited = s.waited + 1;
          if (d[s.ph] || n.waited == TIMEOUT) begin
            n.err = !d[s.ph];
            if (s.ph == 3) n.step = 2;
            else begin
              n.ph = s.ph + 1; n.step = 0;
            end
          end
        end
        default: begin
          n.busy = 0; n.ph = 0;
        end
      endcase
    end
    return n;
  endfunction

  always @(posedge fastclk or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_step(m, tick, pause, done);
  end

  logic [3:0] e_start;
  task automatic compare_cycle();
    e_start = (m.busy && m.step == 0) ? 4'(1 << m.ph) : 4'd0;
    checks++;
    if (start !== e_start || phase !== 2'(m.ph) || busy !== m.busy ||
        frame_done !== (m.busy && m.step == 2) || timeout_err !== m.err ||
        overrun_cnt !== 8'(m.ovr)) begin
      errors++;
      $display("FAIL model_cycle t=%0t start %b/%b phase %0d/%0d busy %b/%b fd %b/%b err %b/%b ovr %0d/%0d (got/exp)",
               $time, start, e_start, phase, m.ph, busy, m.busy, frame_done, (m.busy && m.step == 2),
               timeout_err, m.err, overrun_cnt, m.ovr);
    end
  endtask

  always @(negedge fastclk) if (mon_en) compare_cycle();

  task automatic next();
    @(posedge fastclk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    next();
    tick = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    int n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      next();
      n++;
    end
    chk(name, int'(frame_done), 1);
    next();
  endtask

  logic [3:0] exp_s [10];

  initial begin
    int s1, s2, ec, ecyc, fdc;
    exp_s = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};
    #3 reset = 1'b0;
    mon_en = 1'b1;
    next();
    chk("reset_busy", busy, 0);
    chk("reset_start", start, 0);
    chk("reset_overrun", overrun_cnt, 0);
    next();
    reset = 1'b1;
    next();

    // All units finish immediately: strobes in cycles 1,3,5,7, frame_done in 9.
    done = 4'hF;
    pulse_tick();
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("fast_start_c%0d", c), start, exp_s[c-1]);
      chk($sformatf("fast_fd_c%0d", c), frame_done, (c == 9) ? 1 : 0);
      chk($sformatf("fast_busy_c%0d", c), busy, (c <= 9) ? 1 : 0);
      next();
    end

    // Ball unit stalls: forced advance after 8 WAIT cycles.
    done = 4'b1101;
    s1 = -1; s2 = -1; ec = 0; ecyc = -1; fdc = -1;
    pulse_tick();
    for (int c = 1; c <= 30; c++) begin
      if (start == 4'b0010) s1 = c;
      if (start == 4'b0100) s2 = c;
      if (timeout_err) begin ec++; ecyc = c; end
      if (frame_done) fdc = c;
      next();
    end
    chk("to_start1_cycle", s1, 3);
    chk("to_start2_cycle", s2, 12);
    chk("to_err_count", ec, 1);
    chk("to_err_cycle", ecyc, 12);
    chk("to_frame_done_cycle", fdc, 16);

    // Paused ticks in IDLE are ignored; pause mid-frame does not abort.
    pause = 1'b1;
    pulse_tick();
    for (int c = 0; c < 4; c++) begin
      chk("pause_busy", busy, 0);
      chk("pause_start", start, 0);
      next();
    end
    chk("pause_overrun", overrun_cnt, 0);
    pause = 1'b0;
    done = 4'hF;
    pulse_tick();
    next();
    next();
    pause = 1'b1;
    wait_frame_done("pause_mid_frame_done");
    pause = 1'b0;

    // Only done[phase] matters.
    done = 4'b1000;
    pulse_tick();
    chk("idx_start0", start, 1);
    next();
    for (int c = 2; c <= 6; c++) begin
      chk($sformatf("idx_phase_c%0d", c), phase, 0);
      chk($sformatf("idx_nostart_c%0d", c), start, 0);
      chk($sformatf("idx_busy_c%0d", c), busy, 1);
      if (c < 6) next();
    end
    done = 4'b0001;
    next();
    chk("idx_start1", start, 4'b0010);
    chk("idx_phase1", phase, 1);
    chk("idx_no_err", timeout_err, 0);
    done = 4'hF;
    wait_frame_done("idx_frame_done");

    // Ticks held high while busy saturate the overrun counter.
    done = 4'h0;
    pulse_tick();
    tick = 1'b1;
    for (int i = 0; i < 300; i++) next();
    tick = 1'b0;
    chk("ovr_saturated", overrun_cnt, 255);
    chk("ovr_still_busy", busy, 1);
    wait_frame_done("ovr_frame_done");
    chk("ovr_held", overrun_cnt, 255);

    // Asynchronous reset during WAIT of phase 2.
    done = 4'b0011;
    pulse_tick();
    repeat (5) next();
    chk("rst_pre_phase", phase, 2);
    chk("rst_pre_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_start", start, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_fd", frame_done, 0);
    chk("rst_async_err", timeout_err, 0);
    chk("rst_async_ovr", overrun_cnt, 0);
    chk("rst_async_phase", phase, 0);
    next();
    next();
    reset = 1'b1;
    done = 4'hF;
    pulse_tick();
    chk("rst_restart_start", start, 1);
    chk("rst_restart_phase", phase, 0);
    chk("rst_restart_busy", busy, 1);
    wait_frame_done("rst_restart_frame_done");

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end, checks %0d errors %0d", checks, errors);
    $fatal(1, "bench time limit expired");
  end

endmodule
